// File: rtl/inst_mem_loader.sv
// inst_mem_loader: takes a length-prefixed byte stream, packs the bytes into
// little-endian instruction words and writes them into instruction memory.
// The core is held in reset for the whole load.
module inst_mem_loader #(
  parameter int width  = 32,
  parameter int depth  = 2048,
  parameter int adr_in = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              wr_en,
  output logic [adr_in-1:0] wr_adr,
  output logic [width-1:0]  wr_data,
  output logic              cpu_hold,
  output logic              done,
  output logic              error,
  output logic [adr_in:0]   words_loaded
);

  localparam int BPW  = width / 8;
  localparam int IDXW = (BPW > 1) ? $clog2(BPW) : 1;

  localparam logic [IDXW-1:0]   IDX_LAST = IDXW'(BPW - 1);
  localparam logic [IDXW-1:0]   IDX_ONE  = 1;
  localparam logic [adr_in-1:0] ADR_ONE  = 1;
  localparam logic [adr_in:0]   WRD_ONE  = 1;

  typedef enum logic [2:0] {
    S_IDLE, S_LEN_LO, S_LEN_HI, S_CHECK, S_DATA, S_WRITE, S_DONE, S_ERR
  } state_t;

  state_t              state_q, state_d;
  logic [15:0]         len_q, len_d;
  logic [IDXW-1:0]     idx_q, idx_d;
  logic [width-1:0]    shreg_q, shreg_d;
  logic [adr_in-1:0]   adr_q, adr_d;
  logic [adr_in:0]     words_q, words_d;
  logic                accept;
  logic                last_word;

  // Outputs decode from the state register only, so ready never depends on valid.
  always_comb begin
    byte_ready   = (state_q == S_LEN_LO) || (state_q == S_LEN_HI) || (state_q == S_DATA);
    cpu_hold     = !((state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_ERR));
    wr_en        = (state_q == S_WRITE);
    done         = (state_q == S_DONE);
    error        = (state_q == S_ERR);
    wr_adr       = adr_q;
    wr_data      = shreg_q;
    words_loaded = words_q;
  end

  // Next-state and datapath updates for the load sequence.
  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    idx_d     = idx_q;
    shreg_d   = shreg_q;
    adr_d     = adr_q;
    words_d   = words_q;
    accept    = byte_valid && byte_ready;
    // Word just being written is the Nth one of the load.
    last_word = (32'(words_q) + 32'd1) == 32'(len_q);
    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d = S_LEN_LO;
          words_d = '0;
        end
      end
      S_LEN_LO: begin
        if (accept) begin
          len_d[7:0] = byte_in;
          state_d    = S_LEN_HI;
        end
      end
      S_LEN_HI: begin
        if (accept) begin
          len_d[15:8] = byte_in;
          state_d     = S_CHECK;
        end
      end
      S_CHECK: begin
        if (len_q == 16'd0) begin
          state_d = S_DONE;
        end else if (32'(len_q) > 32'(depth)) begin
          state_d = S_ERR;
        end else begin
          state_d = S_DATA;
          idx_d   = '0;
          adr_d   = '0;
        end
      end
      S_DATA: begin
        if (accept) begin
          // Shift right so the first byte of the word ends up in bits [7:0].
          shreg_d                = shreg_q >> 8;
          shreg_d[width-1 -: 8]  = byte_in;
          if (idx_q == IDX_LAST) begin
            idx_d   = '0;
            state_d = S_WRITE;
          end else begin
            idx_d = idx_q + IDX_ONE;
          end
        end
      end
      S_WRITE: begin
        words_d = words_q + WRD_ONE;
        // Address only advances when another word follows, so it never wraps.
        if (last_word) begin
          state_d = S_DONE;
        end else begin
          state_d = S_DATA;
          adr_d   = adr_q + ADR_ONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      idx_q   <= '0;
      shreg_q <= '0;
      adr_q   <= '0;
      words_q <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
      adr_q   <= adr_d;
      words_q <= words_d;
    end
  end

endmodule

// File: doc/inst_mem_loader.md
# inst_mem_loader

Program loader that fills the instruction memory before the processor runs. It accepts a byte stream (length header followed by instruction bytes) over a valid/ready handshake. It assembles little-endian instruction words and issues one-cycle write strobes into the instruction memory write port. While loading, it holds the core in reset through `cpu_hold`.

## Interface
- `width`, 32: instruction word width in bits; must be a multiple of 8 (BPW = width/8 bytes per word)
- `depth`, 2048: number of instruction memory words
- `adr_in`, 11: address width; `depth` ≤ 2^adr_in

- `clk`  in  1  single clock; all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  begin a load; sampled only in IDLE, DONE, ERR
- `byte_in`  in  8  incoming stream byte
- `byte_valid`  in  1  `byte_in` is valid
- `byte_ready`  out  1  loader can accept a byte this cycle
- `wr_en`  out  1  instruction memory write strobe, one cycle per word
- `wr_adr`  out  adr_in  word write address
- `wr_data`  out  width  assembled instruction word
- `cpu_hold`  out  1  keep processor in reset while high
- `done`  out  1  load finished successfully; level held until next `start` or `rst`
- `error`  out  1  header length exceeded `depth`; level held until next `start` or `rst`
- `words_loaded`  out  adr_in+1  count of words written in the current or last load

## Operation
- Byte transfer occurs on a rising edge with `byte_valid && byte_ready`. With `byte_ready` low, bytes are not consumed; the source holds them.
- Stream format: LEN_LO, LEN_HI (16-bit word count N, little-endian), then N×BPW bytes. Within each word, the first byte goes to bits [7:0] and the last byte to bits [width-1:width-8].
- States and transitions:
  - IDLE: `start` → LEN_LO.
  - LEN_LO: accepts a byte → LEN_HI.
  - LEN_HI: accepts a byte → CHECK.
  - CHECK: takes one cycle, no bytes accepted.
    - N=0 → DONE.
    - N>depth → ERR.
    - otherwise → DATA with byte index 0 and word address 0.
  - DATA: accepts BPW bytes into the shift register. On the BPW-th accept → WRITE.
  - WRITE: `wr_en`=1 for exactly one cycle; `words_loaded` increments. If this was word N-1 → DONE, else → DATA with address+1.
  - DONE: `done`=1. `start` → LEN_LO.
  - ERR: `error`=1. `start` → LEN_LO.
- `byte_ready` is 1 only in LEN_LO, LEN_HI, DATA.
- `cpu_hold` is 1 in every state except IDLE, DONE, ERR.
- On a `start` from DONE or ERR: clear `done`, `error` and `words_loaded`. Old memory contents are not cleared.
- `start` is ignored in LEN_LO, LEN_HI, CHECK, DATA, WRITE.
- N=depth is legal. The final write goes to address depth-1, and the address counter never wraps.
- Extra bytes after the last word are not consumed, because `byte_ready`=0 in DONE.
- Bytes arriving before `start` are not consumed.

## Timing
- Reset values: state IDLE; `byte_ready`=0, `wr_en`=0, `wr_adr`=0, `wr_data`=0, `cpu_hold`=0, `done`=0, `error`=0, `words_loaded`=0. Byte index and shift register are cleared.
- `rst` mid-load forces the above on the next edge. A partially assembled word is discarded with no write.
- All outputs are registered or decoded from the state register only; no combinational path from `byte_valid` to `byte_ready`.
- Latency: the write of a word occurs the cycle after its last byte is accepted. `wr_adr` and `wr_data` are stable in the `wr_en` cycle.
- `done` and `cpu_hold`=0 appear the cycle after the final `wr_en`.
- Minimum load time with continuous valid: 2 + 1 + N×(BPW+1) cycles from the first `byte_ready`.
- `start` to LEN_LO takes one cycle; `cpu_hold` rises in that cycle.

## Test plan
- **Two-word load:** bytes 02 00 | 13 05 A0 00 | 93 05 10 00 with `byte_valid` held high.
  - Writes 0x00A00513 @0, then 0x00100593 @1.
  - `done`=1, `words_loaded`=2, `cpu_hold` falls with `done`.
- **Backpressure and gaps:** same stream with `byte_valid` randomly deasserted.
  - Identical writes and order.
  - No byte accepted while in CHECK or WRITE.
- **N=0:** header 00 00.
  - No `wr_en`; `done`=1 after CHECK.
  - A following byte is not consumed.
- **N=depth+1:** header 01 08 (2049) with the default `depth`.
  - `error`=1, no `wr_en`, `cpu_hold`=0.
  - Then `start` with a valid header loads normally and clears `error`.
- **N=depth:** full load of 2048 words.
  - Last write at 0x7FF, `words_loaded`=2048, no wrap to address 0.
- **Reset mid-load:** assert `rst` after 2 data bytes of word 1.
  - All outputs return to reset values, no `wr_en` for the partial word.
  - A subsequent `start` restarts from the header.
